// File: rtl/reorder_buffer_pkg.sv
// rtl/reorder_buffer_pkg.sv - reorder buffer sizing, entry types and index helper
package reorder_buffer_pkg;

    localparam int RoB_addr = 3;
    localparam int RoB_size = 1 << RoB_addr;

    typedef enum logic [1:0] {
        ROB_REG    = 2'd0,
        ROB_STORE  = 2'd1,
        ROB_BRANCH = 2'd2
    } rob_type_e;

    typedef struct packed {
        rob_type_e   rtype;
        logic [4:0]  rd;
        logic [31:0] value;
        logic        pred_taken;
        logic [31:0] alt_pc;
    } rob_entry_t;

    function automatic logic [RoB_addr-1:0] rob_next(input logic [RoB_addr-1:0] idx);
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular in-order commit queue with result capture and mispredict flush
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                dec_valid,
    input  logic [1:0]          dec_type,
    input  logic [4:0]          dec_rd,
    input  logic                dec_pred_taken,
    input  logic [31:0]         dec_alt_pc,
    output logic                rob_full,
    output logic [RoB_addr-1:0] rob_tail,
    input  logic                RS_valid,
    input  logic [RoB_addr-1:0] RS_RoBindex,
    input  logic [31:0]         RS_value,
    input  logic                LSB_valid,
    input  logic [RoB_addr-1:0] LSB_RoBindex,
    input  logic [31:0]         LSB_value,
    input  logic [RoB_addr-1:0] qj_idx,
    input  logic [RoB_addr-1:0] qk_idx,
    output logic                qj_ready,
    output logic                qk_ready,
    output logic [31:0]         qj_value,
    output logic [31:0]         qk_value,
    output logic                commit_valid,
    output logic [1:0]          commit_type,
    output logic [4:0]          commit_rd,
    output logic [31:0]         commit_value,
    output logic [RoB_addr-1:0] commit_index,
    output logic                flush,
    output logic [31:0]         flush_pc
);

    rob_entry_t          entries [RoB_size];
    logic [RoB_size-1:0] busy;
    logic [RoB_size-1:0] ready;
    logic [RoB_addr-1:0] head;
    logic [RoB_addr-1:0] tail;
    logic [RoB_addr:0]   count;

    logic do_alloc;
    logic do_commit;
    logic mispredict;
    rob_entry_t head_entry;

    assign rob_full = (count == (RoB_addr+1)'(RoB_size));
    assign rob_tail = tail;

    always_comb begin
        head_entry = entries[head];
        do_alloc   = dec_valid && !rob_full;
        do_commit  = (count != '0) && ready[head];
        mispredict = do_commit && (head_entry.rtype == ROB_BRANCH)
                     && (head_entry.value[0] != head_entry.pred_taken);
    end

    // Ready entries answer from storage; otherwise a same-cycle broadcast is forwarded (RS first).
    function automatic logic [32:0] lookup(input logic [RoB_addr-1:0] idx);
        logic [32:0] res;
        res = '0;
        if (busy[idx]) begin
            if (ready[idx])
                res = {1'b1, entries[idx].value};
            else if (RS_valid && RS_RoBindex == idx)
                res = {1'b1, RS_value};
            else if (LSB_valid && LSB_RoBindex == idx)
                res = {1'b1, LSB_value};
        end
        return res;
    endfunction

    always_comb begin
        {qj_ready, qj_value} = lookup(qj_idx);
        {qk_ready, qk_value} = lookup(qk_idx);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            busy         <= '0;
            ready        <= '0;
            commit_valid <= 1'b0;
            commit_type  <= '0;
            commit_rd    <= '0;
            commit_value <= '0;
            commit_index <= '0;
            flush        <= 1'b0;
            flush_pc     <= '0;
        end else if (!rdy_in) begin
            commit_valid <= 1'b0;
            flush        <= 1'b0;
        end else begin
            commit_valid <= do_commit;
            flush        <= mispredict;
            if (do_commit) begin
                commit_type  <= head_entry.rtype;
                commit_rd    <= head_entry.rd;
                commit_value <= head_entry.value;
                commit_index <= head;
            end
            if (mispredict) begin
                // Everything younger than the branch is wrong-path work.
                flush_pc <= head_entry.alt_pc;
                busy     <= '0;
                ready    <= '0;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
            end else begin
                if (LSB_valid && busy[LSB_RoBindex]) begin
                    ready[LSB_RoBindex]         <= 1'b1;
                    entries[LSB_RoBindex].value <= LSB_value;
                end
                // Later assignment wins, so RS takes priority on a shared tag.
                if (RS_valid && busy[RS_RoBindex]) begin
                    ready[RS_RoBindex]         <= 1'b1;
                    entries[RS_RoBindex].value <= RS_value;
                end
                if (do_alloc) begin
                    busy[tail]    <= 1'b1;
                    ready[tail]   <= 1'b0;
                    entries[tail] <= '{rtype: rob_type_e'(dec_type), rd: dec_rd, value: 32'h0,
                                       pred_taken: dec_pred_taken, alt_pc: dec_alt_pc};
                    tail          <= rob_next(tail);
                end
                if (do_commit) begin
                    busy[head]  <= 1'b0;
                    ready[head] <= 1'b0;
                    head        <= rob_next(head);
                end
                count <= count + {{RoB_addr{1'b0}}, do_alloc} - {{RoB_addr{1'b0}}, do_commit};
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed vector bench for reorder_buffer
module tb_reorder_buffer;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        dec_valid, dec_pred_taken;
    logic [1:0]  dec_type;
    logic [4:0]  dec_rd;
    logic [31:0] dec_alt_pc;
    logic        rob_full;
    logic [2:0]  rob_tail;
    logic        RS_valid, LSB_valid;
    logic [2:0]  RS_RoBindex, LSB_RoBindex;
    logic [31:0] RS_value, LSB_value;
    logic [2:0]  qj_idx, qk_idx;
    logic        qj_ready, qk_ready;
    logic [31:0] qj_value, qk_value;
    logic        commit_valid;
    logic [1:0]  commit_type;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value;
    logic [2:0]  commit_index;
    logic        flush;
    logic [31:0] flush_pc;

    reorder_buffer dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .dec_valid(dec_valid), .dec_type(dec_type), .dec_rd(dec_rd),
        .dec_pred_taken(dec_pred_taken), .dec_alt_pc(dec_alt_pc),
        .rob_full(rob_full), .rob_tail(rob_tail),
        .RS_valid(RS_valid), .RS_RoBindex(RS_RoBindex), .RS_value(RS_value),
        .LSB_valid(LSB_valid), .LSB_RoBindex(LSB_RoBindex), .LSB_value(LSB_value),
        .qj_idx(qj_idx), .qk_idx(qk_idx), .qj_ready(qj_ready), .qk_ready(qk_ready),
        .qj_value(qj_value), .qk_value(qk_value),
        .commit_valid(commit_valid), .commit_type(commit_type), .commit_rd(commit_rd),
        .commit_value(commit_value), .commit_index(commit_index),
        .flush(flush), .flush_pc(flush_pc)
    );

    always #5 clk_in = ~clk_in;

    localparam logic       O = 1'b1;
    localparam logic       N = 1'b0;
    localparam logic [1:0] RG = 2'd0;
    localparam logic [1:0] ST = 2'd1;
    localparam logic [1:0] BR = 2'd2;
    localparam logic [31:0] Z = 32'h0;

    typedef struct {
        logic rdy; logic dv; logic [1:0] dt; logic [4:0] rd; logic pt; logic [31:0] apc;
        logic rsv; logic [2:0] rsi; logic [31:0] rsval;
        logic lsv; logic [2:0] lsi; logic [31:0] lsval;
        logic [2:0] q; logic qchk; logic eqr; logic [31:0] eqv;
        logic [2:0] etail; logic efull;
        logic ecv; logic [1:0] ect; logic [4:0] ecrd; logic [31:0] ecval;
        logic efl; logic [31:0] efpc;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        rdy_in = 1'b1; dec_valid = 1'b0; dec_type = 2'd0; dec_rd = 5'd0;
        dec_pred_taken = 1'b0; dec_alt_pc = 32'h0;
        RS_valid = 1'b0; RS_RoBindex = 3'd0; RS_value = 32'h0;
        LSB_valid = 1'b0; LSB_RoBindex = 3'd0; LSB_value = 32'h0;
        qj_idx = 3'd0; qk_idx = 3'd0;
    endtask

    task automatic apply(input vec_t v, input int n);
        string tag;
        tag = $sformatf("v%0d", n);
        rdy_in = v.rdy; dec_valid = v.dv; dec_type = v.dt; dec_rd = v.rd;
        dec_pred_taken = v.pt; dec_alt_pc = v.apc;
        RS_valid = v.rsv; RS_RoBindex = v.rsi; RS_value = v.rsval;
        LSB_valid = v.lsv; LSB_RoBindex = v.lsi; LSB_value = v.lsval;
        qj_idx = v.q; qk_idx = v.q;
        #4;
        if (v.qchk) begin
            chk({tag, " qj_ready"}, 32'(qj_ready), 32'(v.eqr));
            chk({tag, " qj_value"}, qj_value, v.eqv);
            chk({tag, " qk_ready"}, 32'(qk_ready), 32'(v.eqr));
        end
        @(posedge clk_in); #1;
        chk({tag, " rob_tail"}, 32'(rob_tail), 32'(v.etail));
        chk({tag, " rob_full"}, 32'(rob_full), 32'(v.efull));
        chk({tag, " commit_valid"}, 32'(commit_valid), 32'(v.ecv));
        chk({tag, " flush"}, 32'(flush), 32'(v.efl));
        if (v.ecv) begin
            chk({tag, " commit_type"}, 32'(commit_type), 32'(v.ect));
            if (v.ect != ST) begin
                chk({tag, " commit_rd"}, 32'(commit_rd), 32'(v.ecrd));
                chk({tag, " commit_value"}, commit_value, v.ecval);
            end
        end
        if (v.efl) chk({tag, " flush_pc"}, flush_pc, v.efpc);
    endtask

    function automatic vec_t idle(input logic [2:0] et, input logic ef, input logic cv,
                                  input logic [4:0] crd, input logic [31:0] cval);
        return '{O, N, RG, 5'd0, N, Z, N, 3'd0, Z, N, 3'd0, Z, 3'd0, N, N, Z,
                 et, ef, cv, RG, crd, cval, N, Z};
    endfunction

    function automatic vec_t alloc(input logic [1:0] t, input logic [4:0] rd, input logic pt,
                                   input logic [31:0] apc, input logic [2:0] et, input logic ef);
        return '{O, O, t, rd, pt, apc, N, 3'd0, Z, N, 3'd0, Z, 3'd0, N, N, Z,
                 et, ef, N, RG, 5'd0, Z, N, Z};
    endfunction

    initial begin
        drive_idle();
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        chk("reset rob_tail", 32'(rob_tail), 32'd0);
        chk("reset rob_full", 32'(rob_full), 32'd0);
        chk("reset commit_valid", 32'(commit_valid), 32'd0);
        chk("reset flush", 32'(flush), 32'd0);
        chk("reset qj_ready", 32'(qj_ready), 32'd0);
        rst_in = 1'b0;

        // In-order commit behind a not-ready head
        vecs.push_back(alloc(RG, 5'd1, N, Z, 3'd1, N));
        vecs.push_back(alloc(RG, 5'd2, N, Z, 3'd2, N));
        vecs.push_back(alloc(RG, 5'd3, N, Z, 3'd3, N));
        vecs.push_back('{O, N, RG, 5'd0, N, Z, O, 3'd1, 32'h22, N, 3'd0, Z, 3'd1, O, O, 32'h22, 3'd3, N, N, RG, 5'd0, Z, N, Z});
        vecs.push_back('{O, N, RG, 5'd0, N, Z, O, 3'd0, 32'h11, N, 3'd0, Z, 3'd1, O, O, 32'h22, 3'd3, N, N, RG, 5'd0, Z, N, Z});
        vecs.push_back('{O, N, RG, 5'd0, N, Z, N, 3'd0, Z, N, 3'd0, Z, 3'd0, O, O, 32'h11, 3'd3, N, O, RG, 5'd1, 32'h11, N, Z});
        vecs.push_back('{O, N, RG, 5'd0, N, Z, N, 3'd0, Z, N, 3'd0, Z, 3'd0, O, N, Z, 3'd3, N, O, RG, 5'd2, 32'h22, N, Z});
        vecs.push_back(idle(3'd3, N, N, 5'd0, Z));
        vecs.push_back('{O, N, RG, 5'd0, N, Z, O, 3'd2, 32'h33, N, 3'd0, Z, 3'd0, N, N, Z, 3'd3, N, N, RG, 5'd0, Z, N, Z});
        vecs.push_back(idle(3'd3, N, O, 5'd3, 32'h33));
        // Fill all 8 starting at tag 3, tail wraps through 0
        for (int i = 0; i < 8; i++)
            vecs.push_back(alloc(RG, 5'(10 + i), N, Z, 3'(4 + i), (i == 7)));
        vecs.push_back(alloc(RG, 5'd31, N, Z, 3'd3, O));
        vecs.push_back('{O, N, RG, 5'd0, N, Z, O, 3'd3, 32'h103, O, 3'd4, 32'h104, 3'd0, N, N, Z, 3'd3, O, N, RG, 5'd0, Z, N, Z});
        vecs.push_back('{O, O, RG, 5'd31, N, Z, O, 3'd2, 32'h102, O, 3'd5, 32'hABCD, 3'd5, O, O, 32'hABCD, 3'd3, N, O, RG, 5'd10, 32'h103, N, Z});
        vecs.push_back('{O, N, RG, 5'd0, N, Z, O, 3'd6, 32'h106, O, 3'd7, 32'h107, 3'd0, N, N, Z, 3'd3, N, O, RG, 5'd11, 32'h104, N, Z});
        vecs.push_back('{O, N, RG, 5'd0, N, Z, O, 3'd0, 32'h100, O, 3'd1, 32'h101, 3'd2, O, O, 32'h102, 3'd3, N, O, RG, 5'd12, 32'hABCD, N, Z});
        vecs.push_back(idle(3'd3, N, O, 5'd13, 32'h106));
        vecs.push_back(idle(3'd3, N, O, 5'd14, 32'h107));
        vecs.push_back(idle(3'd3, N, O, 5'd15, 32'h100));
        vecs.push_back(idle(3'd3, N, O, 5'd16, 32'h101));
        vecs.push_back(idle(3'd3, N, O, 5'd17, 32'h102));
        vecs.push_back(idle(3'd3, N, N, 5'd0, Z));
        // Mispredicted branch at tag 3 with three younger entries
        vecs.push_back(alloc(BR, 5'd0, O, 32'h1004, 3'd4, N));
        vecs.push_back(alloc(RG, 5'd20, N, Z, 3'd5, N));
        vecs.push_back(alloc(RG, 5'd21, N, Z, 3'd6, N));
        vecs.push_back(alloc(RG, 5'd22, N, Z, 3'd7, N));
        vecs.push_back('{O, N, RG, 5'd0, N, Z, O, 3'd3, 32'h0, N, 3'd0, Z, 3'd0, N, N, Z, 3'd7, N, N, RG, 5'd0, Z, N, Z});
        vecs.push_back('{O, O, RG, 5'd23, N, Z, N, 3'd0, Z, O, 3'd4, 32'h77, 3'd0, N, N, Z, 3'd0, N, O, BR, 5'd0, 32'h0, O, 32'h1004});
        vecs.push_back('{O, N, RG, 5'd0, N, Z, N, 3'd0, Z, N, 3'd0, Z, 3'd4, O, N, Z, 3'd0, N, N, RG, 5'd0, Z, N, Z});
        // Correctly predicted branch: commit without flush
        vecs.push_back(alloc(BR, 5'd0, N, 32'h2000, 3'd1, N));
        vecs.push_back('{O, N, RG, 5'd0, N, Z, O, 3'd0, 32'h0, N, 3'd0, Z, 3'd0, N, N, Z, 3'd1, N, N, RG, 5'd0, Z, N, Z});
        vecs.push_back('{O, N, RG, 5'd0, N, Z, N, 3'd0, Z, N, 3'd0, Z, 3'd0, N, N, Z, 3'd1, N, O, BR, 5'd0, 32'h0, N, Z});
        // rdy_in low holds a ready head and ignores allocation
        vecs.push_back(alloc(RG, 5'd5, N, Z, 3'd2, N));
        vecs.push_back('{O, N, RG, 5'd0, N, Z, O, 3'd1, 32'h55, N, 3'd0, Z, 3'd0, N, N, Z, 3'd2, N, N, RG, 5'd0, Z, N, Z});
        for (int i = 0; i < 3; i++)
            vecs.push_back('{N, O, RG, 5'd6, N, Z, N, 3'd0, Z, N, 3'd0, Z, 3'd0, N, N, Z, 3'd2, N, N, RG, 5'd0, Z, N, Z});
        vecs.push_back(idle(3'd2, N, O, 5'd5, 32'h55));
        // Store commit
        vecs.push_back(alloc(ST, 5'd0, N, Z, 3'd3, N));
        vecs.push_back('{O, N, RG, 5'd0, N, Z, N, 3'd0, Z, O, 3'd2, 32'h0, 3'd0, N, N, Z, 3'd3, N, N, RG, 5'd0, Z, N, Z});
        vecs.push_back('{O, N, RG, 5'd0, N, Z, N, 3'd0, Z, N, 3'd0, Z, 3'd0, N, N, Z, 3'd3, N, O, ST, 5'd0, Z, N, Z});

        foreach (vecs[i]) apply(vecs[i], i);

        // Reset mid-stream with 5 busy entries and a head that just became ready
        drive_idle();
        for (int i = 0; i < 5; i++) begin
            dec_valid = 1'b1; dec_rd = 5'(i + 1);
            @(posedge clk_in); #1;
        end
        chk("pre-reset rob_tail", 32'(rob_tail), 32'd0);
        dec_valid = 1'b0;
        RS_valid = 1'b1; RS_RoBindex = 3'd3; RS_value = 32'h99;
        @(posedge clk_in); #1;
        rst_in = 1'b1; dec_valid = 1'b1; RS_valid = 1'b0;
        @(posedge clk_in); #1;
        rst_in = 1'b0; drive_idle();
        chk("mid reset rob_tail", 32'(rob_tail), 32'd0);
        chk("mid reset rob_full", 32'(rob_full), 32'd0);
        chk("mid reset commit_valid", 32'(commit_valid), 32'd0);
        chk("mid reset flush", 32'(flush), 32'd0);
        @(posedge clk_in); #1;
        chk("post reset commit_valid", 32'(commit_valid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            dec_valid = 1'b1;
            @(posedge clk_in); #1;
            chk($sformatf("refill%0d rob_full", i), 32'(rob_full), 32'(i == 7));
        end
        drive_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order commit queue of the Tomasulo core; sits directly downstream of the reservation station and load/store buffer.
- Allocates one entry per decoded instruction and captures results broadcast by RS/LSB.
- Retires the head entry to the register file / LSB when it is ready, and raises flush on branch mispredict.

Parameters:
- RoB_addr, 3, index width (shared constant in const.v).
- RoB_size, 8, entry count = 2**RoB_addr.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset, synchronous, active-high.
- rdy_in  in  1  global enable; 0 = hold all state.
- dec_valid  in  1  allocate request from decoder.
- dec_type  in  2  0 = reg-write, 1 = store, 2 = branch.
- dec_rd  in  5  destination register (ignored unless type 0).
- dec_pred_taken  in  1  predicted direction (branch only).
- dec_alt_pc  in  32  PC of the not-predicted path (branch only).
- rob_full  out  1  count == RoB_size.
- rob_tail  out  RoB_addr  index the next allocation receives.
- RS_valid  in  1  RS result broadcast.
- RS_RoBindex  in  RoB_addr  RS result tag.
- RS_value  in  32  RS result; bit0 = actual taken for branches.
- LSB_valid  in  1  LSB broadcast; load result, or store ready.
- LSB_RoBindex  in  RoB_addr  LSB result tag.
- LSB_value  in  32  load data (don't-care for stores).
- qj_idx, qk_idx  in  RoB_addr  operand lookup tags from decoder.
- qj_ready, qk_ready  out  1  combinational: tagged entry has its result.
- qj_value, qk_value  out  32  combinational value for the tagged entry.
- commit_valid  out  1  one-cycle retire pulse.
- commit_type  out  2  type of the retired entry.
- commit_rd  out  5  destination register of the retired entry.
- commit_value  out  32  value of the retired entry.
- commit_index  out  RoB_addr  tag retired; used to clear register-file dependencies.
- flush  out  1  one-cycle mispredict pulse.
- flush_pc  out  32  redirect target.

Behaviour:
- State: head, tail, count (RoB_addr+1 bits); per entry busy, ready, type, rd, value, pred_taken, alt_pc.
- Reset (rst_in=1 at posedge): head = tail = count = 0, all busy/ready = 0; every registered output = 0. Reset wins over rdy_in and all other inputs.
- rdy_in = 0: no state change; commit_valid and flush driven 0 that cycle.
- Allocate: dec_valid & !rob_full writes entry[tail] with busy=1, ready=0, then tail+1 (wraps 7->0).
  - dec_valid while full is ignored; the decoder must not issue.
- Writeback: RS_valid / LSB_valid set ready=1 and value on the tagged busy entry.
  - Both valid to different tags: both apply.
  - Both to the same tag: RS wins (protocol error).
  - Writeback to a non-busy tag is ignored.
- Commit, evaluated at posedge:
  - Condition: count > 0 & entry[head].ready.
  - Action: registered commit_* valid in the following cycle; head+1 with wrap; busy cleared.
  - Throughput: at most one commit per cycle.
  - Earliest commit: writeback at edge M makes the entry ready; commit_valid is high after edge M+1.
- Branch commit: commit_valid=1, commit_type=2.
  - If value[0] != pred_taken: also flush=1, flush_pc = alt_pc.
  - Same edge: clear every busy/ready, head = tail = count = 0.
  - Any allocation or writeback in that cycle is discarded.
- Count update: allocate & commit in the same cycle leaves count unchanged.
  - A full buffer that commits does not accept allocation the same cycle, because rob_full is computed from registered count.
- Lookup: q*_ready = entry ready, OR a same-cycle RS/LSB broadcast matching the tag (forwarded value).
  - A non-busy tag returns ready=0, value=0.
- Store commit: commit_type=1 tells the LSB the store at commit_index may write memory; rd/value are don't-care.

Decomposition:
- const.v: `RoB_addr, `RoB_size, type encodings (`ROB_REG, `ROB_STORE, `ROB_BRANCH).
- Single module, no sub-module; entry storage is plain reg arrays indexed by head/tail.

Test Plan:
- Reset, then allocate 3 reg-writes (rd = 1, 2, 3) -> rob_tail = 3, no commit.
  - RS writes tag 1 = 0x22 -> no commit, since head is not ready.
  - Tag 0 = 0x11 -> commits tag 0 (rd 1, 0x11), then tag 1 (rd 2, 0x22) on consecutive cycles.
- Fill 8 entries -> rob_full = 1; a 9th dec_valid is ignored.
  - Complete all 8 -> 8 consecutive commit pulses; tail wraps to 0; count returns to 0.
- Branch pred_taken=1, alt_pc=0x1004, RS_value=0 -> commit_valid with flush=1, flush_pc=0x1004.
  - 3 younger entries discarded; rob_tail = 0 next cycle.
- RS and LSB write tags 2 and 5 in the same cycle -> both ready.
  - qj_idx = 5 in the same cycle as the LSB broadcast 0xABCD -> qj_ready = 1, qj_value = 0xABCD (forward).
- rdy_in = 0 for 3 cycles with a ready head -> no commit; state unchanged.
  - rdy_in back to 1 -> commit on the next edge.
- rst_in asserted mid-stream with 5 busy entries -> next cycle count = 0, commit_valid = 0, flush = 0, rob_full = 0.
